// File: rtl/mod_arbiter.sv
// Round-robin scheduler that shares one `mod` unit among NREQ requesters.
// Define MOD_TIMEOUT_EN to enable the ISSUE-state watchdog (rsp_err on abort).
module mod_arbiter #(
    parameter int unsigned BITS    = 65,
    parameter int unsigned NREQ    = 4,
    parameter int unsigned IDW     = 2,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*BITS-1:0] req_x,
    input  logic [NREQ*BITS-1:0] req_y,
    output logic [NREQ-1:0]      gnt,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [BITS-1:0]      rsp_m,
    output logic                 rsp_err,
    output logic                 busy,
    output logic [BITS-1:0]      mod_x,
    output logic [BITS-1:0]      mod_y,
    output logic                 mod_go,
    input  logic [BITS-1:0]      mod_m,
    input  logic                 mod_done
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StRelease} state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [IDW-1:0]    rsp_id_q, rsp_id_d;
    logic [BITS-1:0]   rsp_m_q, rsp_m_d;
    logic [BITS-1:0]   mod_x_q, mod_x_d;
    logic [BITS-1:0]   mod_y_q, mod_y_d;
    logic              mod_go_q, mod_go_d;

    logic [BITS-1:0]   slot_x [NREQ];
    logic [BITS-1:0]   slot_y [NREQ];
    logic              found;
    logic [PW-1:0]     win;
    logic              timeout;

    for (genvar i = 0; i < NREQ; i++) begin : g_slot
        assign slot_x[i] = req_x[i*BITS +: BITS];
        assign slot_y[i] = req_y[i*BITS +: BITS];
    end

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            int unsigned idx;
            idx = (32'(ptr_q) + k) % NREQ;
            if (!found && req[PW'(idx)]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

`ifdef MOD_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Cleared while idle so it starts at zero on every entry to ISSUE.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StIdle) begin
            cnt_d = '0;
        end else if (state_q == StIssue) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout = (state_q == StIssue) && !mod_done && (cnt_q == CW'(TIMEOUT - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StRelease;
            ptr_q       <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_id_q    <= '0;
            rsp_m_q     <= '0;
            mod_x_q     <= '0;
            mod_y_q     <= '0;
            mod_go_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_id_q    <= rsp_id_d;
            rsp_m_q     <= rsp_m_d;
            mod_x_q     <= mod_x_d;
            mod_y_q     <= mod_y_d;
            mod_go_q    <= mod_go_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (found) state_d = StIssue;
            StIssue:   if (mod_done || timeout) state_d = StRelease;
            StRelease: if (!mod_done) state_d = StIdle;
            default:   state_d = StRelease;
        endcase
    end

    always_comb begin
        ptr_d       = ptr_q;
        gnt_d       = '0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_m_d     = rsp_m_q;
        mod_x_d     = mod_x_q;
        mod_y_d     = mod_y_q;
        mod_go_d    = mod_go_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    mod_x_d  = slot_x[win];
                    mod_y_d  = slot_y[win];
                    mod_go_d = 1'b1;
                    gnt_d    = NREQ'(1) << win;
                    rsp_id_d = IDW'(win);
                    ptr_d    = PW'((32'(win) + 32'd1) % NREQ);
                end
            end
            StIssue: begin
                if (mod_done) begin
                    rsp_m_d     = mod_m;
                    rsp_valid_d = 1'b1;
                    mod_go_d    = 1'b0;
                end else if (timeout) begin
                    rsp_m_d     = '0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    mod_go_d    = 1'b0;
                end
            end
            default: mod_go_d = 1'b0;
        endcase
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_m     = rsp_m_q;
    assign mod_x     = mod_x_q;
    assign mod_y     = mod_y_q;
    assign mod_go    = mod_go_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mod_arbiter.sv
// Self-checking bench for mod_arbiter with a behavioural `mod` unit model.
// Honours MOD_TIMEOUT_EN the same way as the design.
module tb_mod_arbiter;

    localparam int unsigned BITS    = 65;
    localparam int unsigned NREQ    = 4;
    localparam int unsigned IDW     = 2;
    localparam int unsigned TIMEOUT = 16;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ*BITS-1:0] req_x, req_y;
    logic [NREQ-1:0]      gnt;
    logic                 rsp_valid, rsp_err, busy, mod_go;
    logic [IDW-1:0]       rsp_id;
    logic [BITS-1:0]      rsp_m, mod_x, mod_y;
    logic [BITS-1:0]      mod_m;
    logic                 mod_done;

    logic [BITS-1:0] ox [NREQ];
    logic [BITS-1:0] oy [NREQ];

    // mod model knobs
    logic            force_done = 1'b0;
    logic            never = 1'b0;
    logic            model_done = 1'b0;
    logic [BITS-1:0] model_m = '0;
    int unsigned     go_cnt = 0;

    int checks = 0;
    int errors = 0;
    int unsigned ptr_m = 0;

    always #5 clk = ~clk;

    always_comb begin
        req_x = '0;
        req_y = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_x[i*BITS +: BITS] = ox[i];
            req_y[i*BITS +: BITS] = oy[i];
        end
    end

    // done rises 5 cycles after go, falls 1 cycle after go drops
    always @(posedge clk) begin
        if (!mod_go) begin
            go_cnt     <= 0;
            model_done <= 1'b0;
        end else begin
            if (go_cnt < 5) go_cnt <= go_cnt + 1;
            model_done <= (go_cnt >= 4) && !never;
            model_m    <= (mod_y == 0) ? '0 : mod_x % mod_y;
        end
    end

    assign mod_done = force_done | model_done;
    assign mod_m    = model_m;

    mod_arbiter #(
        .BITS(BITS), .NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_x(req_x), .req_y(req_y),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_m(rsp_m),
        .rsp_err(rsp_err), .busy(busy), .mod_x(mod_x), .mod_y(mod_y),
        .mod_go(mod_go), .mod_m(mod_m), .mod_done(mod_done)
    );

    task automatic check(input string name, input logic [BITS-1:0] act,
                         input logic [BITS-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expired(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired, got no event expected one", name);
    endtask

    function automatic int unsigned pick(input logic [NREQ-1:0] m, input int unsigned p);
        for (int k = 0; k < NREQ; k++) begin
            if (m[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return 0;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ptr_m = 0;
    endtask

    task automatic wait_gnt(output int lat, output bit ok);
        lat = 0;
        while (gnt == '0 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        ok = (gnt != '0);
    endtask

    // One full job: grant to w, then a response carrying em.
    task automatic job(input int unsigned w, input logic [BITS-1:0] em, input bit clear,
                       output int lat);
        bit ok;
        int n;
        wait_gnt(lat, ok);
        if (!ok) begin
            expired("gnt_wait");
            return;
        end
        check("gnt", BITS'(gnt), BITS'(1) << w);
        check("mod_go", BITS'(mod_go), 1);
        check("mod_x", mod_x, ox[w]);
        check("mod_y", mod_y, oy[w]);
        check("busy", BITS'(busy), 1);
        ptr_m = (w + 1) % NREQ;
        if (clear) req[w] = 1'b0;
        @(negedge clk);
        check("gnt_pulse", BITS'(gnt), 0);
        n = 0;
        while (!rsp_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) begin
            expired("rsp_wait");
            return;
        end
        check("rsp_id", BITS'(rsp_id), BITS'(w));
        check("rsp_m", rsp_m, em);
        check("rsp_err", BITS'(rsp_err), 0);
        @(negedge clk);
        check("rsp_pulse", BITS'(rsp_valid), 0);
    endtask

    typedef struct {
        logic [NREQ-1:0] rq;
        int unsigned     win;
        logic [BITS-1:0] x;
        logic [BITS-1:0] y;
        logic [BITS-1:0] m;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int lat;
        int n;
        bit ok;
        bit bad;
        logic [BITS-1:0] two64;
        two64 = '0;
        two64[64] = 1'b1;

        vecs[0] = '{rq: 4'b0001, win: 0, x: 4,           y: 21,    m: 4};
        vecs[1] = '{rq: 4'b0010, win: 1, x: 100,         y: 7,     m: 2};
        vecs[2] = '{rq: 4'b1010, win: 3, x: 50,          y: 9,     m: 5};
        vecs[3] = '{rq: 4'b0010, win: 1, x: 50,          y: 9,     m: 5};
        vecs[4] = '{rq: 4'b0001, win: 0, x: 1073602561,  y: two64, m: 1073602561};
        vecs[5] = '{rq: 4'b1111, win: 1, x: 123456789,   y: 1000,  m: 789};
        vecs[6] = '{rq: 4'b0101, win: 2, x: 0,           y: 5,     m: 0};
        vecs[7] = '{rq: 4'b0001, win: 0, x: 7,           y: 7,     m: 0};

        for (int i = 0; i < NREQ; i++) begin
            ox[i] = '0;
            oy[i] = 1;
        end

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_gnt", BITS'(gnt), 0);
        check("rst_rsp_valid", BITS'(rsp_valid), 0);
        check("rst_rsp_err", BITS'(rsp_err), 0);
        check("rst_mod_go", BITS'(mod_go), 0);
        check("rst_rsp_id", BITS'(rsp_id), 0);
        check("rst_rsp_m", rsp_m, 0);
        check("rst_mod_x", mod_x, 0);
        check("rst_mod_y", mod_y, 0);
        check("rst_busy", BITS'(busy), 1);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Directed vectors
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < NREQ; i++) begin
                ox[i] = vecs[v].x;
                oy[i] = vecs[v].y;
            end
            req = vecs[v].rq;
            job(vecs[v].win, vecs[v].m, 1'b1, lat);
            if (v == 0) check("req_to_gnt_latency", BITS'(lat), 1);
            if (v == 4) check("mod_y_bit64", BITS'(mod_y[64]), 1);
            req = '0;
        end

        // All requesters held from reset release
        for (int i = 0; i < NREQ; i++) begin
            ox[i] = BITS'(1000 + 37 * i);
            oy[i] = BITS'(11 + i);
        end
        req = '1;
        do_reset();
        for (int j = 0; j < 5; j++) begin
            job(j % NREQ, ox[j % NREQ] % oy[j % NREQ], 1'b0, lat);
        end
        req = '0;

        // Reset during ISSUE with done held high
        req = 4'b0100;
        wait_gnt(lat, ok);
        if (!ok) expired("rst_issue_gnt");
        check("rst_issue_gnt", BITS'(gnt), 4);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        force_done = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ptr_m = 0;
        check("rst_issue_go", BITS'(mod_go), 0);
        check("rst_issue_valid", BITS'(rsp_valid), 0);
        check("rst_issue_busy", BITS'(busy), 1);
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (gnt != '0 || rsp_valid) bad = 1'b1;
        end
        check("stale_done_holdoff", BITS'(bad), 0);
        force_done = 1'b0;
        job(2, ox[2] % oy[2], 1'b1, lat);

        // Unit never completes
        never = 1'b1;
        req = 4'b0001;
        wait_gnt(lat, ok);
        if (!ok) expired("hang_gnt");
        check("hang_gnt", BITS'(gnt), 1);
        req = '0;
`ifdef MOD_TIMEOUT_EN
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) expired("timeout_rsp");
        check("timeout_latency", BITS'(n), 16);
        check("timeout_err", BITS'(rsp_err), 1);
        check("timeout_m", rsp_m, 0);
        check("timeout_id", BITS'(rsp_id), 0);
        never = 1'b0;
        ptr_m = 1;
        req = 4'b0110;
        job(pick(req, ptr_m), ox[1] % oy[1], 1'b1, lat);
        req = '0;
`else
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (!busy || rsp_valid || !mod_go) bad = 1'b1;
        end
        check("no_timeout_wait", BITS'(bad), 0);
        never = 1'b0;
`endif
        do_reset();

        // Randomised traffic against the round-robin reference
        for (int it = 0; it < 25; it++) begin
            int unsigned w;
            for (int i = 0; i < NREQ; i++) begin
                ox[i] = BITS'({$urandom(), $urandom(), $urandom()});
                oy[i] = BITS'({$urandom(), $urandom(), $urandom()}) >> $urandom_range(0, 63);
                if (oy[i] == '0) oy[i] = 1;
            end
            req = NREQ'($urandom_range(1, 15));
            while (req != '0) begin
                w = pick(req, ptr_m);
                job(w, ox[w] % oy[w], 1'b1, lat);
                if ($urandom_range(0, 3) == 0) req[$urandom_range(0, NREQ - 1)] = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
